// File: rtl/dac_threshold_wr_if.sv
// Threshold write request bus between the channel measurement controller (master)
// and the threshold DAC writer (slave).
interface dac_threshold_wr_if;
  logic [15:0] threshold_i;
  logic        threshold_wre_i;
  logic        threshold_rdy_o;
  logic        wr_drop_o;

  modport master (output threshold_i, threshold_wre_i, input  threshold_rdy_o, wr_drop_o);
  modport slave  (input  threshold_i, threshold_wre_i, output threshold_rdy_o, wr_drop_o);
endinterface

// File: rtl/dac_threshold_wr.sv
// Threshold DAC writer: serializes 16-bit codes into 24-bit SPI mode-0 frames,
// waits analog settling, and keeps a one-deep latest-wins pending buffer.
module dac_threshold_wr #(
  parameter int          CLK_DIV       = 2,
  parameter int          SETTLE_CYCLES = 50,
  parameter logic [7:0]  DAC_CMD       = 8'h30
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  dac_threshold_wr_if.slave    req,
  output logic                 dac_cs_n_o,
  output logic                 dac_sclk_o,
  output logic                 dac_mosi_o
);
  localparam int PH_W = $clog2(CLK_DIV + 1);
  localparam int ST_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, SETTLE} state_e;

  state_e            state_q, state_d;
  logic [23:0]       shreg_q, shreg_d;
  logic [4:0]        bit_q, bit_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic              pend_q, pend_d;
  logic [15:0]       pcode_q, pcode_d;
  logic              rdy_q, rdy_d;
  logic              drop_q, drop_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              start;
  logic [15:0]       start_code;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    ph_d       = ph_q;
    st_d       = st_q;
    pend_d     = pend_q;
    pcode_d    = pcode_q;
    rdy_d      = rdy_q;
    drop_d     = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    start      = 1'b0;
    start_code = req.threshold_i;

    // Writes while busy queue up; the frame on the wire is never touched.
    if (req.threshold_wre_i && state_q != IDLE) begin
      pend_d  = 1'b1;
      pcode_d = req.threshold_i;
      drop_d  = pend_q;
    end

    case (state_q)
      IDLE: if (req.threshold_wre_i) start = 1'b1;
      SHIFT: begin
        if (ph_q != PH_LAST) begin
          ph_d = ph_q + PH_W'(1);
        end else if (!sclk_q) begin
          ph_d   = '0;
          sclk_d = 1'b1;
        end else begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == 5'd23) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[22:0], 1'b0};
            mosi_d  = shreg_q[22];
          end
        end
      end
      HOLD: begin
        if (ph_q != PH_LAST) begin
          ph_d = ph_q + PH_W'(1);
        end else begin
          ph_d    = '0;
          cs_n_d  = 1'b1;
          st_d    = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (SETTLE_CYCLES == 0 || st_q == ST_LAST) begin
          // An incoming write at the decision point beats the older pending code.
          if (req.threshold_wre_i) begin
            start  = 1'b1;
            drop_d = pend_q;
            pend_d = 1'b0;
          end else if (pend_q) begin
            start      = 1'b1;
            start_code = pcode_q;
            pend_d     = 1'b0;
          end else begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end
        end else begin
          st_d = st_q + ST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SHIFT;
      shreg_d = {DAC_CMD, start_code};
      mosi_d  = DAC_CMD[7];
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      rdy_d   = 1'b0;
      bit_d   = '0;
      ph_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      st_q    <= '0;
      pend_q  <= 1'b0;
      pcode_q <= '0;
      rdy_q   <= 1'b1;
      drop_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      st_q    <= st_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
      rdy_q   <= rdy_d;
      drop_q  <= drop_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign req.threshold_rdy_o = rdy_q;
  assign req.wr_drop_o       = drop_q;
  assign dac_cs_n_o          = cs_n_q;
  assign dac_sclk_o          = sclk_q;
  assign dac_mosi_o          = mosi_q;
endmodule

// File: tb/tb_dac_threshold_wr.sv
// Directed bench for dac_threshold_wr with default parameters: SPI frame monitor,
// run-length tracking of rdy/cs_n, and drop pulse counting.
module tb_dac_threshold_wr;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic cs_n, sclk, mosi;

  dac_threshold_wr_if bus ();

  dac_threshold_wr dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .req        (bus),
    .dac_cs_n_o (cs_n),
    .dac_sclk_o (sclk),
    .dac_mosi_o (mosi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] sh;
  int          nbits;
  logic [23:0] frames[$];
  int          fbits[$];
  int rdy_run = 0, last_rdy_low = 0;
  int cs_low_run = 0, last_cs_low = 0;
  int cs_high_run = 0, last_cs_high = 0;
  int drop_cnt = 0, cs_low_total = 0;

  always @(posedge sclk) if (!cs_n) begin sh = {sh[22:0], mosi}; nbits++; end
  always @(negedge cs_n) begin sh = '0; nbits = 0; end
  always @(posedge cs_n) begin frames.push_back(sh); fbits.push_back(nbits); end

  always @(negedge clk) if (!arst) begin
    if (!bus.threshold_rdy_o) rdy_run++;
    else if (rdy_run != 0) begin last_rdy_low = rdy_run; rdy_run = 0; end
    if (!cs_n) begin
      cs_low_run++; cs_low_total++;
      if (cs_high_run != 0) begin last_cs_high = cs_high_run; cs_high_run = 0; end
    end else begin
      cs_high_run++;
      if (cs_low_run != 0) begin last_cs_low = cs_low_run; cs_low_run = 0; end
    end
    if (bus.wr_drop_o) drop_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_wre(input logic [15:0] code);
    @(negedge clk);
    bus.threshold_i     = code;
    bus.threshold_wre_i = 1'b1;
    @(negedge clk);
    bus.threshold_wre_i = 1'b0;
  endtask

  task automatic wait_rdy(input string name, input int budget);
    int i;
    for (i = 0; i < budget && bus.threshold_rdy_o !== 1'b1; i++) @(negedge clk);
    chk({name, "_rdy_timeout"}, bus.threshold_rdy_o, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_stats();
    frames.delete(); fbits.delete(); drop_cnt = 0;
  endtask

  typedef struct {
    logic [15:0] code;
    logic [23:0] frame;
  } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{16'hA5C3, 24'h30A5C3};
    vecs[1] = '{16'h0000, 24'h300000};
    vecs[2] = '{16'hFFFF, 24'h30FFFF};
    vecs[3] = '{16'h8001, 24'h308001};

    bus.threshold_i = '0;
    bus.threshold_wre_i = 1'b0;
    #12;
    chk("rst_rdy", bus.threshold_rdy_o, 1'b1);
    chk("rst_drop", bus.wr_drop_o, 1'b0);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    reset_stats();

    repeat (1000) @(negedge clk);
    chk("idle_cs_low_total", cs_low_total, 0);
    chk("idle_rdy", bus.threshold_rdy_o, 1'b1);
    chk("idle_frames", frames.size(), 0);

    for (int v = 0; v < 4; v++) begin
      reset_stats();
      set_wre(vecs[v].code);
      chk("single_rdy_fell", bus.threshold_rdy_o, 1'b0);
      wait_rdy("single", 400);
      chk("single_nframes", frames.size(), 1);
      if (frames.size() == 1) begin
        chk("single_frame", frames[0], vecs[v].frame);
        chk("single_bits", fbits[0], 24);
      end
      chk("single_cs_low", last_cs_low, 98);
      chk("single_rdy_low", last_rdy_low, 148);
      chk("single_drop", drop_cnt, 0);
    end

    // Back-to-back: second write queued 10 cycles into the first frame.
    reset_stats();
    set_wre(16'h0001);
    repeat (8) @(negedge clk);
    set_wre(16'h0002);
    wait_rdy("b2b", 800);
    chk("b2b_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("b2b_frame0", frames[0], 24'h300001);
      chk("b2b_frame1", frames[1], 24'h300002);
    end
    chk("b2b_gap", last_cs_high, 50);
    chk("b2b_rdy_low", last_rdy_low, 296);
    chk("b2b_drop", drop_cnt, 0);

    // Overwrite: 2222 is replaced by 3333 before it is ever sent.
    reset_stats();
    set_wre(16'h1111);
    repeat (4) @(negedge clk);
    set_wre(16'h2222);
    repeat (4) @(negedge clk);
    set_wre(16'h3333);
    wait_rdy("ovw", 800);
    chk("ovw_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("ovw_frame0", frames[0], 24'h301111);
      chk("ovw_frame1", frames[1], 24'h303333);
    end
    chk("ovw_drop", drop_cnt, 1);

    // Write lands exactly on the last SETTLE cycle (edge 148 after the accepting edge).
    reset_stats();
    @(negedge clk);
    bus.threshold_i = 16'h1111; bus.threshold_wre_i = 1'b1;
    @(negedge clk); bus.threshold_wre_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.threshold_i = 16'h4444; bus.threshold_wre_i = 1'b1;
    @(negedge clk); bus.threshold_wre_i = 1'b0;
    repeat (137) @(negedge clk);
    chk("edge_pre_cs_n", cs_n, 1'b1);
    bus.threshold_i = 16'h5555; bus.threshold_wre_i = 1'b1;
    @(negedge clk); bus.threshold_wre_i = 1'b0;
    chk("edge_new_frame_cs_n", cs_n, 1'b0);
    wait_rdy("edge", 800);
    chk("edge_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("edge_frame0", frames[0], 24'h301111);
      chk("edge_frame1", frames[1], 24'h305555);
    end
    chk("edge_drop", drop_cnt, 1);
    chk("edge_gap", last_cs_high, 50);

    // Asynchronous reset in the middle of bit 10.
    reset_stats();
    set_wre(16'h1234);
    for (int i = 0; i < 200 && nbits < 10; i++) @(negedge clk);
    chk("arst_reached_bit10", nbits, 10);
    chk("arst_sclk_high_before", sclk, 1'b1);
    #2 arst = 1'b1;
    #1;
    chk("arst_cs_n_async", cs_n, 1'b1);
    chk("arst_sclk_async", sclk, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("arst_rdy_after", bus.threshold_rdy_o, 1'b1);
    chk("arst_partial_bits", (fbits.size() == 1) ? fbits[0] : -1, 10);
    repeat (5) @(negedge clk);
    chk("arst_no_restart", cs_n, 1'b1);
    reset_stats();
    set_wre(16'hBEEF);
    wait_rdy("post_arst", 400);
    chk("post_arst_nframes", frames.size(), 1);
    if (frames.size() == 1) begin
      chk("post_arst_frame", frames[0], 24'h30BEEF);
      chk("post_arst_bits", fbits[0], 24);
    end
    chk("post_arst_rdy_low", last_rdy_low, 148);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
